// File: rtl/debounce_pkg.sv
// Shared types and limits for the input debouncer and its helpers.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   localparam int DEBOUNCE_MIN = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/debouncer_fsm.sv
// Synchronizes and debounces a raw input into a clean registered level,
// counting rejected transitions (glitches) in a saturating counter.
module debouncer_fsm
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
   parameter int GLITCH_W        = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_raw,
   input  logic                clr_glitch,
   output logic                db_out,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   if (DEBOUNCE_CYCLES < DEBOUNCE_MIN) begin : g_param_check
      $error("debouncer_fsm: DEBOUNCE_CYCLES must be at least 2");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s2;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             glitch_evt;
   logic             db_nxt;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (in_raw),
      .q     (s2)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE_LO;
         cnt    <= '0;
         db_out <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         db_out <= db_nxt;
      end
   end

   // A WAIT state that sees the old level again abandons the candidate and flags a glitch.
   always_comb begin
      state_nxt  = IDLE_LO;
      cnt_nxt    = '0;
      glitch_evt = 1'b0;
      case (state)
         IDLE_LO: begin
            if (s2) begin
               state_nxt = WAIT_HI;
               cnt_nxt   = CNT_W'(1);
            end else begin
               state_nxt = IDLE_LO;
            end
         end
         WAIT_HI: begin
            if (!s2) begin
               state_nxt  = IDLE_LO;
               glitch_evt = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE_HI;
            end else begin
               state_nxt = WAIT_HI;
               cnt_nxt   = cnt + CNT_W'(1);
            end
         end
         IDLE_HI: begin
            if (!s2) begin
               state_nxt = WAIT_LO;
               cnt_nxt   = CNT_W'(1);
            end else begin
               state_nxt = IDLE_HI;
            end
         end
         WAIT_LO: begin
            if (s2) begin
               state_nxt  = IDLE_HI;
               glitch_evt = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE_LO;
            end else begin
               state_nxt = WAIT_LO;
               cnt_nxt   = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE_LO;
         end
      endcase
   end

   // db_out is registered from the next state so downstream sees a clean flop output.
   always_comb begin
      busy   = (state == WAIT_HI) || (state == WAIT_LO);
      db_nxt = (state_nxt == IDLE_HI) || (state_nxt == WAIT_LO);
   end

   // A same-cycle clear takes priority over a glitch event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         glitch_cnt <= '0;
      end else if (clr_glitch) begin
         glitch_cnt <= '0;
      end else if (glitch_evt && (glitch_cnt != {GLITCH_W{1'b1}})) begin
         glitch_cnt <= glitch_cnt + GLITCH_W'(1);
      end
   end

endmodule

// File: tb/tb_debouncer_fsm.sv
// Self-checking bench for debouncer_fsm: directed scenarios plus randomized runs against a run-length model.
module tb_debouncer_fsm;

   localparam int D  = 4;
   localparam int GW = 2;
   localparam int GMAX = (1 << GW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_raw = 1'b0;
   logic          clr_glitch = 1'b0;
   logic          db_out;
   logic          busy;
   logic [GW-1:0] glitch_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   debouncer_fsm #(.DEBOUNCE_CYCLES(D), .GLITCH_W(GW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_raw     (in_raw),
      .clr_glitch (clr_glitch),
      .db_out     (db_out),
      .busy       (busy),
      .glitch_cnt (glitch_cnt)
   );

   always #5 clk = ~clk;

   // Model: the level flips once D consecutive FSM samples disagree with it;
   // a disagreeing run broken by an agreeing sample is one glitch.
   logic m_s1 = 1'b0;
   logic m_s2 = 1'b0;
   logic m_db = 1'b0;
   int   m_run = 0;
   int   m_glitch = 0;

   always @(posedge clk or negedge rst_n) begin
      logic smp;
      logic evt;
      if (!rst_n) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0; m_run = 0; m_glitch = 0;
      end else begin
         smp = m_s2;
         evt = 1'b0;
         if (smp != m_db) begin
            m_run++;
            if (m_run == D) begin
               m_db  = ~m_db;
               m_run = 0;
            end
         end else begin
            if (m_run > 0) evt = 1'b1;
            m_run = 0;
         end
         if (clr_glitch) m_glitch = 0;
         else if (evt && m_glitch < GMAX) m_glitch++;
         m_s2 = m_s1;
         m_s1 = in_raw;
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      in_raw = 1'b0;
      clr_glitch = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_raw = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (db_out !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_db: got %b expected 0", db_out); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++;
      if (glitch_cnt !== '0) begin n_bad++; $display("[TB] FAIL reset_glitch: got %0d expected 0", glitch_cnt); end
      in_raw = 1'b0;
   endtask

   task automatic test_clean_rise();
      apply_reset();
      in_raw = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         n_cmp++;
         if (db_out !== (e >= 6)) begin n_bad++; $display("[TB] FAIL rise_db E%0d: got %b expected %b", e, db_out, (e >= 6)); end
         n_cmp++;
         if (busy !== (e >= 3 && e <= 5)) begin n_bad++; $display("[TB] FAIL rise_busy E%0d: got %b expected %b", e, busy, (e >= 3 && e <= 5)); end
      end
      n_cmp++;
      if (glitch_cnt !== 2'd0) begin n_bad++; $display("[TB] FAIL rise_glitch: got %0d expected 0", glitch_cnt); end
   endtask

   task automatic test_short_pulse();
      apply_reset();
      step();
      in_raw = 1'b1;
      repeat (3) step();
      in_raw = 1'b0;
      for (int e = 0; e < 8; e++) begin
         step();
         n_cmp++;
         if (db_out !== 1'b0) begin n_bad++; $display("[TB] FAIL pulse_db cycle %0d: got %b expected 0", e, db_out); end
      end
      n_cmp++;
      if (glitch_cnt !== 2'd1) begin n_bad++; $display("[TB] FAIL pulse_glitch: got %0d expected 1", glitch_cnt); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL pulse_busy: got %b expected 0", busy); end
   endtask

   task automatic test_bounce_settle();
      logic [5:0] pat;
      pat = 6'b101101;
      apply_reset();
      for (int e = 1; e <= 14; e++) begin
         in_raw = (e <= 6) ? pat[6-e] : 1'b1;
         step();
         n_cmp++;
         if (db_out !== (e >= 11)) begin n_bad++; $display("[TB] FAIL bounce_db edge %0d: got %b expected %b", e, db_out, (e >= 11)); end
      end
      n_cmp++;
      if (glitch_cnt !== 2'd2) begin n_bad++; $display("[TB] FAIL bounce_glitch: got %0d expected 2", glitch_cnt); end
   endtask

   task automatic test_saturation_clear();
      int exp_g;
      apply_reset();
      for (int g = 1; g <= 5; g++) begin
         in_raw = 1'b1;
         step();
         in_raw = 1'b0;
         repeat (4) step();
         exp_g = (g < GMAX) ? g : GMAX;
         n_cmp++;
         if (glitch_cnt !== GW'(exp_g)) begin n_bad++; $display("[TB] FAIL sat_glitch #%0d: got %0d expected %0d", g, glitch_cnt, exp_g); end
      end
      in_raw = 1'b1;
      step();
      in_raw = 1'b0;
      step();
      step();
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL sat_busy_before_clear: got %b expected 1", busy); end
      clr_glitch = 1'b1;
      step();
      clr_glitch = 1'b0;
      n_cmp++;
      if (glitch_cnt !== 2'd0) begin n_bad++; $display("[TB] FAIL clear_wins: got %0d expected 0", glitch_cnt); end
      repeat (3) step();
      n_cmp++;
      if (glitch_cnt !== 2'd0) begin n_bad++; $display("[TB] FAIL clear_stays: got %0d expected 0", glitch_cnt); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      in_raw = 1'b1;
      step();
      in_raw = 1'b0;
      repeat (4) step();
      n_cmp++;
      if (glitch_cnt !== 2'd1) begin n_bad++; $display("[TB] FAIL mid_pre_glitch: got %0d expected 1", glitch_cnt); end
      in_raw = 1'b1;
      repeat (4) step();
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_busy: got %b expected 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (db_out !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_rst_db: got %b expected 0", db_out); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", busy); end
      n_cmp++;
      if (glitch_cnt !== 2'd0) begin n_bad++; $display("[TB] FAIL mid_rst_glitch: got %0d expected 0", glitch_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         step();
         n_cmp++;
         if (db_out !== (e >= 6)) begin n_bad++; $display("[TB] FAIL mid_release_db E%0d: got %b expected %b", e, db_out, (e >= 6)); end
      end
      n_cmp++;
      if (glitch_cnt !== 2'd0) begin n_bad++; $display("[TB] FAIL mid_release_glitch: got %0d expected 0", glitch_cnt); end
   endtask

   task automatic test_falling_edge();
      int   falls;
      logic prev;
      apply_reset();
      in_raw = 1'b1;
      repeat (10) step();
      n_cmp++;
      if (db_out !== 1'b1) begin n_bad++; $display("[TB] FAIL fall_start_db: got %b expected 1", db_out); end
      in_raw = 1'b0;
      falls = 0;
      prev = db_out;
      for (int e = 1; e <= 8; e++) begin
         step();
         if (prev && !db_out) falls++;
         prev = db_out;
         n_cmp++;
         if (db_out !== (e < 6)) begin n_bad++; $display("[TB] FAIL fall_db E%0d: got %b expected %b", e, db_out, (e < 6)); end
      end
      n_cmp++;
      if (falls != 1) begin n_bad++; $display("[TB] FAIL fall_count: got %0d expected 1", falls); end
      n_cmp++;
      if (glitch_cnt !== 2'd0) begin n_bad++; $display("[TB] FAIL fall_glitch: got %0d expected 0", glitch_cnt); end
   endtask

   task automatic test_random();
      logic val;
      int   len;
      apply_reset();
      for (int b = 0; b < 80; b++) begin
         val = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 2 * D);
         for (int c = 0; c < len; c++) begin
            in_raw = val;
            clr_glitch = ($urandom_range(0, 15) == 0);
            step();
            n_cmp++;
            if (db_out !== m_db) begin n_bad++; $display("[TB] FAIL rand_db burst %0d: got %b expected %b", b, db_out, m_db); end
            n_cmp++;
            if (busy !== (m_run > 0)) begin n_bad++; $display("[TB] FAIL rand_busy burst %0d: got %b expected %b", b, busy, (m_run > 0)); end
            n_cmp++;
            if (glitch_cnt !== GW'(m_glitch)) begin n_bad++; $display("[TB] FAIL rand_glitch burst %0d: got %0d expected %0d", b, glitch_cnt, m_glitch); end
         end
      end
      clr_glitch = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_rise();
      test_short_pulse();
      test_bounce_settle();
      test_saturation_clear();
      test_reset_mid();
      test_falling_edge();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
